// File: rtl/tlc_phase_sched_if.sv
// Lamp/phase bus between the traffic-light phase scheduler and its environment.
// Pedestrian request/acknowledge signals exist only when PED_XING_EN is defined.
interface tlc_phase_sched_if;
    logic       CLR;
    logic       FM;
    logic       TEST;
`ifdef PED_XING_EN
    logic       PED_REQ;
    logic       PED_ACK;
`endif
    logic       GRN1;
    logic       YLW1;
    logic       RED1;
    logic       GRN2;
    logic       YLW2;
    logic       RED2;
    logic [2:0] PHASE;

    modport master (
        output CLR, FM, TEST,
`ifdef PED_XING_EN
        output PED_REQ,
        input  PED_ACK,
`endif
        input  GRN1, YLW1, RED1, GRN2, YLW2, RED2, PHASE
    );

    modport slave (
        input  CLR, FM, TEST,
`ifdef PED_XING_EN
        input  PED_REQ,
        output PED_ACK,
`endif
        output GRN1, YLW1, RED1, GRN2, YLW2, RED2, PHASE
    );
endinterface

// File: rtl/tlc_phase_sched.sv
// Two-road traffic-light phase scheduler with one elapsed-cycle counter.
// Optional pedestrian service is compiled in with `define PED_XING_EN.
module tlc_phase_sched #(
    parameter int GRN_MIN_CYC = 16,
    parameter int GRN_MAX_CYC = 64,
    parameter int YLW_CYC     = 4,
    parameter int ALLRED_CYC  = 2,
    parameter int CNT_W       = 8
) (
    input  logic                blif_clk_net,
    input  logic                blif_reset_net,
    tlc_phase_sched_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_G1 = 3'd0,
        ST_Y1 = 3'd1,
        ST_R1 = 3'd2,
        ST_G2 = 3'd3,
        ST_Y2 = 3'd4,
        ST_R2 = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MIN_M1   = CNT_W'(GRN_MIN_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_M1   = CNT_W'(GRN_MAX_CYC - 1);
    localparam logic [CNT_W-1:0] YLW_M1   = CNT_W'(YLW_CYC - 1);
    localparam logic [CNT_W-1:0] RED_M1   = CNT_W'(ALLRED_CYC - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dmin_m1_s, dmax_m1_s, dy_m1_s, dr_m1_s;
    logic             adv_s;
    logic             ped_pend_s;

    function automatic state_e next_phase(input state_e cur);
        case (cur)
            ST_G1:   next_phase = ST_Y1;
            ST_Y1:   next_phase = ST_R1;
            ST_R1:   next_phase = ST_G2;
            ST_G2:   next_phase = ST_Y2;
            ST_Y2:   next_phase = ST_R2;
            ST_R2:   next_phase = ST_G1;
            default: next_phase = ST_R2;
        endcase
    endfunction

    // Effective phase limits (minus one); fast mode collapses every phase to one cycle.
    always_comb begin
        if (bus.TEST) begin
            dmin_m1_s = CNT_ZERO;
            dmax_m1_s = CNT_ZERO;
            dy_m1_s   = CNT_ZERO;
            dr_m1_s   = CNT_ZERO;
        end else begin
            dmin_m1_s = MIN_M1;
            dmax_m1_s = MAX_M1;
            dy_m1_s   = YLW_M1;
            dr_m1_s   = RED_M1;
        end
    end

    // Phase-exit decision and next state/counter values.
    always_comb begin
        adv_s = 1'b0;
        case (state_q)
            ST_G1:   adv_s = (cnt_q >= dmin_m1_s) && (bus.FM || ped_pend_s);
            ST_Y1:   adv_s = (cnt_q == dy_m1_s);
            ST_R1:   adv_s = (cnt_q == dr_m1_s);
            ST_G2:   adv_s = ((cnt_q >= dmin_m1_s) && !bus.FM) || (cnt_q >= dmax_m1_s);
            ST_Y2:   adv_s = (cnt_q == dy_m1_s);
            ST_R2:   adv_s = (cnt_q == dr_m1_s);
            default: adv_s = 1'b1;
        endcase
        if (adv_s) begin
            state_d = next_phase(state_q);
            cnt_d   = CNT_ZERO;
        end else begin
            state_d = state_q;
            cnt_d   = (cnt_q >= MAX_M1) ? MAX_M1 : (cnt_q + CNT_ONE);
        end
    end

    // Phase register; CLR is an emergency abort straight to all-red with no yellow.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            state_q <= ST_R2;
            cnt_q   <= CNT_ZERO;
        end else if (bus.CLR) begin
            state_q <= ST_R2;
            cnt_q   <= CNT_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PED_XING_EN
    logic ped_pend_q, ped_pend_d, ped_ack_s;

    // Acknowledge on the first farm-green cycle; a same-cycle request re-arms.
    always_comb begin
        ped_ack_s = (state_q == ST_G2) && (cnt_q == CNT_ZERO) && ped_pend_q;
        if (bus.PED_REQ) begin
            ped_pend_d = 1'b1;
        end else if (ped_ack_s) begin
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = ped_pend_q;
        end
    end

    // Pending pedestrian request survives CLR; only reset drops it.
    always_ff @(posedge blif_clk_net) begin
        if (blif_reset_net) begin
            ped_pend_q <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
        end
    end

    assign ped_pend_s  = ped_pend_q;
    assign bus.PED_ACK = ped_ack_s;
`else
    assign ped_pend_s = 1'b0;
`endif

    // Lamp decode from the state register; any illegal code shows all-red.
    always_comb begin
        bus.GRN1 = 1'b0;
        bus.YLW1 = 1'b0;
        bus.RED1 = 1'b1;
        bus.GRN2 = 1'b0;
        bus.YLW2 = 1'b0;
        bus.RED2 = 1'b1;
        case (state_q)
            ST_G1: begin
                bus.GRN1 = 1'b1;
                bus.RED1 = 1'b0;
            end
            ST_Y1: begin
                bus.YLW1 = 1'b1;
                bus.RED1 = 1'b0;
            end
            ST_G2: begin
                bus.GRN2 = 1'b1;
                bus.RED2 = 1'b0;
            end
            ST_Y2: begin
                bus.YLW2 = 1'b1;
                bus.RED2 = 1'b0;
            end
            default: begin
                bus.RED1 = 1'b1;
                bus.RED2 = 1'b1;
            end
        endcase
    end

    assign bus.PHASE = state_q;

endmodule
